// File: rtl/pwm_dac_out_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_dac_out_if : sample valid/ready handshake into the PWM DAC output stage
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pwm_dac_out_if #(
    parameter int M = 12
) ();
    logic [M-1:0] in;
    logic         in_valid;
    logic         in_ready;

    modport master (
        output in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in,
        input  in_valid,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_dac_out.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_dac_out : 2^M-tick PWM DAC with single-entry pending buffer, duty
// committed at period wrap. Option macro: PWM_DAC_OUT_SIGNED_IN_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pwm_dac_out #(
    parameter int M   = 12,
    parameter int DIV = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pwm_dac_out_if.slave     bus,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);
    localparam logic [M-1:0] c_cnt_max = '1;

    logic         w_tick;
    logic         w_wrap;
    logic         w_accept;
    logic [M-1:0] w_in_conv;

    logic [M-1:0] r_cnt;
    logic [M-1:0] r_duty;
    logic [M-1:0] r_pend;
    logic         r_pend_full;

    generate
        if (DIV == 1) begin : g_div_bypass
            assign w_tick = 1'b1;
        end else begin : g_div_cnt
            localparam int DIV_W = $clog2(DIV);
            localparam logic [DIV_W-1:0] c_div_max = DIV_W'(DIV - 1);
            logic [DIV_W-1:0] r_div_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == c_div_max) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end

            assign w_tick = (r_div_cnt == c_div_max);
        end
    endgenerate

`ifdef PWM_DAC_OUT_SIGNED_IN_EN
    // Two's complement to offset binary: flipping the sign bit recentres 0 at mid-scale.
    assign w_in_conv = {~bus.in[M-1], bus.in[M-2:0]};
`else
    assign w_in_conv = bus.in;
`endif

    assign w_wrap       = w_tick && (r_cnt == c_cnt_max);
    assign bus.in_ready = !r_pend_full;
    assign w_accept     = bus.in_valid && !r_pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_duty       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= r_cnt + M'(1);
            end
            pwm_out      <= (r_cnt < r_duty);
            period_start <= w_wrap;
            underrun     <= w_wrap && !r_pend_full;
            // Commit needs a full buffer and accept needs an empty one, so they never collide.
            if (w_wrap && r_pend_full) begin
                r_duty      <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= w_in_conv;
                r_pend_full <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/pwm_dac_out.md
Name: pwm_dac_out

Overview:
- Output stage directly downstream of the per-voice output multiplexer. Consumes the selected m-bit unsigned sample through a valid/ready handshake.
- Samples are held in a single-entry pending buffer. A new duty value is committed only at a PWM period boundary.
- Drives a 1-bit PWM pin for the external RC filter. Emits a period-start strobe for upstream sample pacing and an underrun pulse when no new sample arrived in time.

Parameters:
- m, 12, sample width; the PWM period is 2^m ticks.
- DIV, 1, clock prescaler; one PWM tick every DIV clk cycles; DIV >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in  input  m  sample from the output mux (unsigned, offset binary)
- in_valid  input  1  sample on `in` is valid
- in_ready  output  1  pending buffer can accept a sample
- pwm_out  output  1  PWM output, registered
- period_start  output  1  one-cycle pulse, registered; a new period began
- underrun  output  1  one-cycle pulse, registered; a period began with the pending buffer empty

Behaviour:
- Reset values: div_cnt=0, cnt=0, duty=0, pend=0, pend_full=0, pwm_out=0, period_start=0, underrun=0. `in_ready` therefore reads 1 after reset.
- Prescaler:
  - div_cnt counts 0..DIV-1.
  - tick = (div_cnt == DIV-1); div_cnt returns to 0 on tick.
  - With DIV=1, tick=1 on every cycle.
- Period counter:
  - cnt (m bits) increments on tick and wraps 2^m-1 -> 0.
  - wrap = tick && cnt == 2^m-1.
- Handshake:
  - in_ready = !pend_full, derived combinationally from the register.
  - Accept occurs when in_valid && in_ready. On accept: pend <= in, pend_full <= 1.
  - `in` may change freely while in_ready=0; it is not sampled.
- Commit on wrap:
  - If pend_full: duty <= pend, pend_full <= 0.
  - Else: duty holds its value, underrun <= 1 for one cycle.
  - period_start <= 1 for one cycle on every wrap.
  - Accept and commit never occur in the same cycle, because in_ready=0 whenever a commit happens. An accept in the wrap cycle with the buffer empty fills pend but does not commit; that sample is committed at the next wrap.
- PWM output:
  - Every clk edge: pwm_out <= (cnt < duty), using pre-edge cnt and duty.
  - High time is duty ticks per period.
  - duty=0 gives a constant 0. duty=2^m-1 gives low for exactly 1 tick per period.
- Latency:
  - Accept to commit: up to one full period (2^m*DIV cycles).
  - Commit to pwm_out reflecting the new duty: 1 cycle.
- Reset mid-operation: all state returns to reset values on the next edge. A pending sample is discarded. pwm_out is low the cycle after rst is sampled.
- Outputs other than in_ready have no combinational path from the inputs.

Optional Feature:
- Macro: PWM_DAC_OUT_SIGNED_IN_EN.
- Defined: `in` is two's complement. The stored value is {~in[m-1], in[m-2:0]}, converted to offset binary at accept. So 0 maps to duty 2^(m-1), and -2^(m-1) maps to 0.
- Undefined: `in` is stored unchanged as unsigned. No conversion logic is synthesized.

Test Plan (m=4, DIV=1 unless noted; macro undefined unless noted):
- Reset then idle 40 cycles -> pwm_out stays 0. in_ready=1 throughout. underrun and period_start each pulse on the cycles after cnt=15, i.e. every 16 cycles.
- Send in=5 with in_valid one cycle at cnt=3 -> in_ready drops the next cycle. At wrap, pend commits and in_ready returns to 1. Following period: pwm_out high exactly 5 cycles, then low 11. No underrun at that wrap.
- Hold in_valid=1 with in=9, then in=12 -> only the first value is accepted while pend_full. in_ready returns high after the wrap, then 12 is accepted. Duty sequence across periods is 9, 12.
- Samples in=0 then in=15 -> one period with pwm_out constantly 0, then a period with pwm_out high 15 cycles and low 1 cycle.
- DIV=3, in=4 -> period is 48 cycles. pwm_out high 12 consecutive cycles per period. period_start pulses every 48 cycles.
- Assert rst mid-period with pend_full=1 and duty=7 -> next cycle all outputs are at reset values. The discarded sample never appears on pwm_out.
- (PWM_DAC_OUT_SIGNED_IN_EN) in=4'b1000 (-8) gives duty 0; in=0 gives duty 8, i.e. 8 high / 8 low.
